// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode classes, FSM state encoding and default widths for the memory/write-back stage
package mips_pkg;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_OP_W    = 5;
   localparam int DEF_RA_W    = 3;
   localparam int DEF_TIMEOUT = 15;
   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_LOAD  = 5'b10100;
   localparam logic [4:0] OP_STORE = 5'b10101;
   typedef enum logic {ST_IDLE = 1'b0, ST_MEM_WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts MEM_WAIT cycles and flags the cycle in which the access has used its whole budget
module mem_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [7:0] cnt_q, cnt_d;
   // clear has priority so a completing access leaves the counter at zero
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 8'd1 : cnt_q;
   // counter register
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   // cnt_q holds completed wait cycles, so the TIMEOUT-th wait cycle is the last one allowed
   assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: routes ALU results to write-back or through a req/ack data-memory access with timeout
module mem_writeback_stage import mips_pkg::*; #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int RA_W    = DEF_RA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_ex,
   input  logic [OP_W-1:0]   op_ex,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] DM_data,
   input  logic [3:0]        flag_ex,
   input  logic [RA_W-1:0]   rd_ex,
   output logic              stall_ex,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_en,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flag_wb,
   output logic              err_timeout
);
   state_t state_q, state_d;
   logic is_load, is_store, is_mem, is_alu, accept, done, expired;
   logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, wb_en_q, wb_en_d, err_q, err_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, wb_data_q, wb_data_d;
   logic [RA_W-1:0] rd_q, rd_d, wb_addr_q, wb_addr_d;
   logic [3:0] flag_q, flag_d;
   assign is_load  = op_ex == OP_W'(OP_LOAD);
   assign is_store = op_ex == OP_W'(OP_STORE);
   assign is_mem   = is_load || is_store;
   assign is_alu   = !is_mem && op_ex != OP_W'(OP_NOP);
   assign accept   = state_q == ST_IDLE && valid_ex;
   assign done     = state_q == ST_MEM_WAIT && (mem_ack || expired);
   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (state_d == ST_IDLE),
      .en_i      (state_q == ST_MEM_WAIT),
      .expired_o (expired)
   );
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= ST_IDLE;
      else state_q <= state_d;
   // enter MEM_WAIT on an accepted load/store, leave on ack or timeout
   always_comb state_d = (accept && is_mem) ? ST_MEM_WAIT : done ? ST_IDLE : state_q;
   // next values of the memory interface, write-back port and sticky error
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_d        = rd_q;
      wb_en_d     = 1'b0;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      flag_d      = flag_q;
      err_d       = err_q;
      if (accept && is_mem) begin
         mem_req_d  = 1'b1;
         mem_we_d   = is_store;
         mem_addr_d = ans_ex;
         rd_d       = rd_ex;
         if (is_store) mem_wdata_d = DM_data;
      end else if (accept && is_alu) begin
         flag_d = flag_ex;
         if (rd_ex != '0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_ex;
            wb_data_d = ans_ex;
         end
      end else if (done) begin
         mem_req_d = 1'b0;
         if (mem_ack && !mem_we_q && rd_q != '0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = mem_rdata;
         end else if (!mem_ack) err_d = 1'b1;
      end
   end
   // output and latched-destination registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_q        <= '0;
         wb_en_q     <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         flag_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_q        <= rd_d;
         wb_en_q     <= wb_en_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         flag_q      <= flag_d;
         err_q       <= err_d;
      end
   assign stall_ex    = state_q == ST_MEM_WAIT;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign wb_en       = wb_en_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign flag_wb     = flag_q;
   assign err_timeout = err_q;
endmodule
